// File: rtl/frequency_measurement_scheduler_pkg.sv
// Shared types for the frequency measurement scheduler: FSM states,
// register-port operation codes and the result mux index width.
package frequency_measurement_scheduler_pkg;

    localparam int SELECT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MEASURE,
        ST_DUMP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        REG_OP_NONE  = 2'd0,
        REG_OP_WRITE = 2'd2
    } reg_op_t;

endpackage

// File: rtl/frequency_measurement_scheduler_if.sv
// Result mux select/data and register-write port between the scheduler
// (master) and the analyzer result register file (slave).
interface frequency_measurement_scheduler_if;
    import frequency_measurement_scheduler_pkg::*;

    logic [SELECT_W-1:0] result_select;
    logic [31:0]         result_data;
    logic [1:0]          register_operation;
    logic [7:0]          register_number;
    logic [31:0]         register_write;

    modport master (
        output result_select, register_operation, register_number, register_write,
        input  result_data
    );

    modport slave (
        input  result_select, register_operation, register_number, register_write,
        output result_data
    );
endinterface

// File: rtl/frequency_measurement_scheduler_counter.sv
// Loadable 32-bit down-counter; terminal is high while the count is zero.
// count_next is exported so the owner can register outputs one cycle early.
module measurement_window_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] count_next,
    output logic        terminal
);
    logic [31:0] count;

    always_comb begin
        count_next = count;
        if (load)
            count_next = load_value;
        else if (count != '0)
            count_next = count - 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else
            count <= count_next;
    end

    assign terminal = (count == '0);
endmodule

// File: rtl/frequency_measurement_scheduler.sv
// Clear -> measure window -> register dump -> irq sequencer for the analyzers.
// Optional FREQUENCY_SCHEDULER_AUTO_REPEAT_EN adds auto_repeat (ack restarts).
module frequency_measurement_scheduler
    import frequency_measurement_scheduler_pkg::*;
#(
    parameter int unsigned DEFAULT_WINDOW_CYCLES = 100000000,
    parameter int          REGISTERS_NUMBER      = 7,
    parameter int          CLEAR_CYCLES          = 2,
    parameter int          HOLD_CYCLES           = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_abort,
    input  logic [31:0] window_cycles,
    output logic        analyzer_enable,
    output logic        analyzer_clear,
    output logic        busy,
    output logic        irq,
    input  logic        irq_ack,
    output logic [15:0] window_count,
`ifdef FREQUENCY_SCHEDULER_AUTO_REPEAT_EN
    input  logic        auto_repeat,
`endif
    frequency_measurement_scheduler_if.master bus
);
    localparam logic [31:0]         CLEAR_LAST  = 32'(CLEAR_CYCLES - 1);
    localparam logic [31:0]         HOLD_LAST   = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0]         CAPTURE_AT  = 32'(HOLD_CYCLES - 2);
    localparam logic [31:0]         DEFAULT_LEN = 32'(DEFAULT_WINDOW_CYCLES);
    localparam logic [SELECT_W-1:0] LAST_SLOT   = SELECT_W'(REGISTERS_NUMBER);

    state_t              state_q, state_d;
    logic [SELECT_W-1:0] slot_q, slot_d;
    logic [31:0]         win_len_q, win_len_d;
    logic [15:0]         count_q;
    logic                window_done;
    logic                repeat_req;

    logic        cnt_load, cnt_tc;
    logic [31:0] cnt_load_value, cnt_next;

    logic                clear_d, enable_d, busy_d, irq_d;
    logic [SELECT_W-1:0] select_d;
    logic [1:0]          op_d;
    logic [7:0]          number_d;
    logic [31:0]         write_d;

`ifdef FREQUENCY_SCHEDULER_AUTO_REPEAT_EN
    assign repeat_req = auto_repeat;
`else
    assign repeat_req = 1'b0;
`endif

    // One counter times every phase: reloaded on each phase/slot entry.
    measurement_window_counter u_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .count_next (cnt_next),
        .terminal   (cnt_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            win_len_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            win_len_q <= win_len_d;
            if (window_done)
                count_q <= count_q + 16'd1;
        end
    end

    // Abort is checked first so it also wins over a start in IDLE.
    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        win_len_d      = win_len_q;
        cnt_load       = 1'b0;
        cnt_load_value = CLEAR_LAST;
        window_done    = 1'b0;
        if (cmd_abort) begin
            state_d = ST_IDLE;
            slot_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (cmd_start) begin
                    win_len_d = (window_cycles == '0) ? DEFAULT_LEN : window_cycles;
                    state_d   = ST_CLEAR;
                    cnt_load  = 1'b1;
                end
                ST_CLEAR: if (cnt_tc) begin
                    state_d        = ST_MEASURE;
                    cnt_load       = 1'b1;
                    cnt_load_value = win_len_q - 32'd1;
                end
                ST_MEASURE: if (cnt_tc) begin
                    state_d        = ST_DUMP;
                    slot_d         = SELECT_W'(1);
                    cnt_load       = 1'b1;
                    cnt_load_value = HOLD_LAST;
                end
                ST_DUMP: if (cnt_tc) begin
                    if (slot_q == LAST_SLOT) begin
                        state_d     = ST_DONE;
                        slot_d      = '0;
                        window_done = 1'b1;
                    end else begin
                        slot_d         = slot_q + SELECT_W'(1);
                        cnt_load       = 1'b1;
                        cnt_load_value = HOLD_LAST;
                    end
                end
                ST_DONE: if (irq_ack) begin
                    if (repeat_req) begin
                        state_d  = ST_CLEAR;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state/count so they land in flops.
    always_comb begin
        clear_d  = (state_d == ST_CLEAR);
        enable_d = (state_d == ST_MEASURE);
        busy_d   = (state_d != ST_IDLE);
        irq_d    = (state_d == ST_DONE);
        select_d = '0;
        op_d     = REG_OP_NONE;
        number_d = '0;
        write_d  = '0;
        if (state_d == ST_DUMP) begin
            select_d = slot_d;
            write_d  = bus.register_write;
            if (cnt_next != HOLD_LAST) begin
                op_d     = REG_OP_WRITE;
                number_d = 8'(slot_d);
            end
            // result_data already reflects this slot's select during s = 0.
            if (cnt_next == CAPTURE_AT)
                write_d = bus.result_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            analyzer_clear         <= 1'b0;
            analyzer_enable        <= 1'b0;
            busy                   <= 1'b0;
            irq                    <= 1'b0;
            bus.result_select      <= '0;
            bus.register_operation <= REG_OP_NONE;
            bus.register_number    <= '0;
            bus.register_write     <= '0;
        end else begin
            analyzer_clear         <= clear_d;
            analyzer_enable        <= enable_d;
            busy                   <= busy_d;
            irq                    <= irq_d;
            bus.result_select      <= select_d;
            bus.register_operation <= op_d;
            bus.register_number    <= number_d;
            bus.register_write     <= write_d;
        end
    end

    assign window_count = count_q;
endmodule

// File: tb/tb_frequency_measurement_scheduler.sv
// Self-checking bench: directed vector table, hand sequences, then random
// stimulus against a cycle-offset reference model.
module tb_frequency_measurement_scheduler;
    localparam int C   = 2;
    localparam int H   = 4;
    localparam int R   = 7;
    localparam int DEF = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_start, cmd_abort, irq_ack;
    logic [31:0] window_cycles;
    logic        analyzer_enable, analyzer_clear, busy, irq;
    logic [15:0] window_count;
`ifdef FREQUENCY_SCHEDULER_AUTO_REPEAT_EN
    logic        auto_repeat;
`endif

    frequency_measurement_scheduler_if bus();
    assign bus.result_data = 32'h100 + 32'(bus.result_select);

    always #5 clock = ~clock;

    frequency_measurement_scheduler #(
        .DEFAULT_WINDOW_CYCLES (DEF),
        .REGISTERS_NUMBER      (R),
        .CLEAR_CYCLES          (C),
        .HOLD_CYCLES           (H)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_start       (cmd_start),
        .cmd_abort       (cmd_abort),
        .window_cycles   (window_cycles),
        .analyzer_enable (analyzer_enable),
        .analyzer_clear  (analyzer_clear),
        .busy            (busy),
        .irq             (irq),
        .irq_ack         (irq_ack),
        .window_count    (window_count),
`ifdef FREQUENCY_SCHEDULER_AUTO_REPEAT_EN
        .auto_repeat     (auto_repeat),
`endif
        .bus             (bus)
    );

    typedef struct packed {
        logic        clr;
        logic        en;
        logic [3:0]  sel;
        logic [1:0]  op;
        logic [7:0]  num;
        logic [31:0] wd;
        logic        busy;
        logic        irq;
        logic [15:0] wc;
    } out_t;

    typedef struct {
        logic [31:0] win;
        int          abort_at;
        int          restart_at;
        int          early_ack_at;
        int          exp_clear;
        int          exp_enable;
        int          exp_en_first;
        logic [15:0] exp_mask;
        int          exp_irq_at;
        int          exp_wc_inc;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.clr  = analyzer_clear;
        o.en   = analyzer_enable;
        o.sel  = bus.result_select;
        o.op   = bus.register_operation;
        o.num  = bus.register_number;
        o.wd   = bus.register_write;
        o.busy = busy;
        o.irq  = irq;
        o.wc   = window_count;
        return o;
    endfunction

    // Reference model: k = cycles since the accepted start (1 = first CLEAR cycle).
    bit          m_run = 0;
    longint      m_k   = 0;
    longint      m_len = 0;
    logic [15:0] m_wc  = '0;

    task automatic model_step(input bit st, input bit ab, input bit ack, input bit rep,
                              input logic [31:0] win);
        longint dk;
        dk = C + m_len + R * H + 1;
        if (!m_run) begin
            if (st && !ab) begin
                m_run = 1;
                m_k   = 1;
                m_len = (win == 0) ? DEF : longint'(win);
            end
        end else if (ab) begin
            m_run = 0;
        end else if (m_k == dk) begin
            if (ack) begin
                if (rep) m_k = 1;
                else     m_run = 0;
            end
        end else begin
            m_k++;
            if (m_k == dk) m_wc++;
        end
    endtask

    task automatic model_out(output out_t e, output out_t m);
        longint ds, dk, i, s;
        e    = '0;
        m    = '1;
        e.wc = m_wc;
        if (m_run) begin
            ds     = C + m_len + 1;
            dk     = ds + R * H;
            e.busy = 1'b1;
            if (m_k <= C) e.clr = 1'b1;
            else if (m_k < ds) e.en = 1'b1;
            else if (m_k < dk) begin
                i     = (m_k - ds) / H + 1;
                s     = (m_k - ds) % H;
                e.sel = 4'(i);
                if (s >= 1) begin
                    e.op  = 2'd2;
                    e.num = 8'(i);
                    e.wd  = 32'h100 + 32'(i);
                end else begin
                    m.num = '0;
                    m.wd  = '0;
                end
            end else e.irq = 1'b1;
        end
    endtask

    task automatic wait_irq(input int limit);
        int n;
        n = 0;
        while (!irq && n < limit) begin
            @(posedge clock); #1;
            n++;
        end
        check("irq_wait", 96'(irq), 96'(1));
    endtask

    vec_t        vecs[5];
    logic [15:0] wc_exp;
    int          clr_n, en_n, en_first, irq_first;
    logic [15:0] mask;
    bit          overlap;
    longint      lx;
    int          slot;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'd10, -1,  5,  6, 2, 10,  3, 16'h00FE, 41, 1};
        vecs[1] = '{32'd0,  -1, -1, -1, 2, 20,  3, 16'h00FE, 51, 1};
        vecs[2] = '{32'd1,  -1, -1, -1, 2,  1,  3, 16'h00FE, 32, 1};
        vecs[3] = '{32'd10, 22, -1, -1, 2, 10,  3, 16'h000E, -1, 0};
        vecs[4] = '{32'd5,   1, -1, -1, 1,  0, -1, 16'h0000, -1, 0};

        reset = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; irq_ack = 1'b0;
        window_cycles = '0;
`ifdef FREQUENCY_SCHEDULER_AUTO_REPEAT_EN
        auto_repeat = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", 96'(dut_out()), 96'(0));
        reset  = 1'b0;
        wc_exp = '0;

        for (int v = 0; v < 5; v++) begin
            clr_n = 0; en_n = 0; en_first = -1; irq_first = -1; mask = '0; overlap = 0;
            lx = (vecs[v].win == 0) ? DEF : longint'(vecs[v].win);
            window_cycles = vecs[v].win;
            cmd_start     = 1'b1;
            for (int n = 1; n <= 70; n++) begin
                @(posedge clock); #1;
                cmd_start     = (n == vecs[v].restart_at);
                window_cycles = (n == vecs[v].restart_at) ? 32'd3 : vecs[v].win;
                cmd_abort     = (n == vecs[v].abort_at);
                irq_ack       = (n == vecs[v].early_ack_at);
                if (analyzer_clear) clr_n++;
                if (analyzer_enable) begin
                    en_n++;
                    if (en_first < 0) en_first = n;
                end
                if (analyzer_clear && analyzer_enable) overlap = 1;
                if (bus.register_operation == 2'd2) begin
                    slot = int'((longint'(n) - (C + lx + 1)) / H + 1);
                    mask[bus.register_number[3:0]] = 1'b1;
                    check("wr_number", 96'(bus.register_number), 96'(slot));
                    check("wr_data", 96'(bus.register_write), 96'(32'h100 + 32'(slot)));
                end
                if (irq && irq_first < 0) irq_first = n;
            end
            cmd_start = 1'b0; cmd_abort = 1'b0; irq_ack = 1'b0;
            check("clear_cycles", 96'(clr_n), 96'(vecs[v].exp_clear));
            check("enable_cycles", 96'(en_n), 96'(vecs[v].exp_enable));
            check("enable_first", 96'(en_first), 96'(vecs[v].exp_en_first));
            check("clear_enable_overlap", 96'(overlap), 96'(0));
            check("written_regs", 96'(mask), 96'(vecs[v].exp_mask));
            check("irq_first", 96'(irq_first), 96'(vecs[v].exp_irq_at));
            wc_exp = wc_exp + 16'(vecs[v].exp_wc_inc);
            check("window_count", 96'(window_count), 96'(wc_exp));
            irq_ack = 1'b1;
            @(posedge clock); #1;
            irq_ack = 1'b0;
            check("ack_irq_low", 96'(irq), 96'(0));
            check("ack_idle", 96'(busy), 96'(0));
        end

        // start and abort together in IDLE: nothing starts
        window_cycles = 32'd4; cmd_start = 1'b1; cmd_abort = 1'b1;
        @(posedge clock); #1;
        cmd_start = 1'b0; cmd_abort = 1'b0;
        check("start_abort_busy", 96'(busy), 96'(0));
        @(posedge clock); #1;
        check("start_abort_clear", 96'({busy, analyzer_clear}), 96'(0));

`ifdef FREQUENCY_SCHEDULER_AUTO_REPEAT_EN
        auto_repeat = 1'b0; window_cycles = 32'd2; cmd_start = 1'b1;
        @(posedge clock); #1;
        cmd_start = 1'b0;
        wait_irq(100);
        wc_exp++;
        auto_repeat = 1'b1; irq_ack = 1'b1;
        @(posedge clock); #1;
        auto_repeat = 1'b0; irq_ack = 1'b0;
        check("repeat_clear", 96'(analyzer_clear), 96'(1));
        check("repeat_irq_low", 96'(irq), 96'(0));
        wait_irq(100);
        wc_exp++;
        check("repeat_wc", 96'(window_count), 96'(wc_exp));
        irq_ack = 1'b1;
        @(posedge clock); #1;
        irq_ack = 1'b0;
        check("repeat_idle", 96'(busy), 96'(0));
`endif

        // reset in the middle of MEASURE
        window_cycles = 32'd10; cmd_start = 1'b1;
        repeat (5) begin
            @(posedge clock); #1;
            cmd_start = 1'b0;
        end
        check("pre_reset_enable", 96'(analyzer_enable), 96'(1));
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("reset_in_measure", 96'(dut_out()), 96'(0));

        // randomized run against the model
        m_run = 0; m_wc = '0;
        for (int n = 0; n < 3000; n++) begin
            bit          r_st, r_ab, r_ack, r_rep;
            logic [31:0] r_win;
            out_t        e, m, a;
            r_st  = ($urandom_range(0, 7) == 0);
            r_ab  = ($urandom_range(0, 99) == 0);
            r_ack = ($urandom_range(0, 3) == 0);
            r_win = 32'($urandom_range(0, 6));
`ifdef FREQUENCY_SCHEDULER_AUTO_REPEAT_EN
            r_rep = ($urandom_range(0, 1) == 0);
            auto_repeat = r_rep;
`else
            r_rep = 1'b0;
`endif
            cmd_start = r_st; cmd_abort = r_ab; irq_ack = r_ack; window_cycles = r_win;
            @(posedge clock);
            model_step(r_st, r_ab, r_ack, r_rep, r_win);
            #1;
            model_out(e, m);
            a = dut_out();
            check("random_model", 96'(a & m), 96'(e & m));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frequency_measurement_scheduler.md
# frequency_measurement_scheduler

Sequencer for the three-point frequency analyzers and the AXI result register file. On a start command it clears the analyzers, enables them for a programmable window of clock cycles, then walks the result registers (1..REGISTERS_NUMBER) through the register-write port. It raises `irq` when the dump is complete and holds it until software acknowledges. It replaces free-running start/stop strobes with one deterministic, cycle-counted measurement window per command.

## Interface
- `DEFAULT_WINDOW_CYCLES`, 100000000: window length used when `window_cycles` = 0.
- `REGISTERS_NUMBER`, 7: number of result registers dumped; max 15.
- `CLEAR_CYCLES`, 2: cycles `analyzer_clear` is held high before the window; min 1.
- `HOLD_CYCLES`, 4: cycles per register-write slot; min 2.
- `clock`  in  1  single clock, all logic on its rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `cmd_start`  in  1  one-cycle start request.
- `cmd_abort`  in  1  one-cycle abort request.
- `window_cycles`  in  32  window length in `clock` cycles; latched on accepted start.
- `analyzer_enable`  out  1  enable to all analyzers.
- `analyzer_clear`  out  1  clear to all analyzers, active-high.
- `result_select`  out  4  result mux index, 0 = none.
- `result_data`  in  32  mux output for `result_select`; combinational, valid in the cycle after `result_select` changes.
- `register_operation`  out  2  0 = none, 2 = write.
- `register_number`  out  8  target register.
- `register_write`  out  32  write data.
- `busy`  out  1  high in any state except IDLE.
- `irq`  out  1  dump complete.
- `irq_ack`  in  1  clears `irq`.
- `window_count`  out  16  completed windows; wraps 0xFFFF -> 0.

## Operation
- States: IDLE, CLEAR, MEASURE, DUMP, DONE.
- IDLE:
  - Outputs are 0.
  - On `cmd_start`: latch the window length (`window_cycles`, or `DEFAULT_WINDOW_CYCLES` if `window_cycles` = 0), then go to CLEAR.
- CLEAR:
  - `analyzer_clear` = 1 for exactly `CLEAR_CYCLES` cycles, then MEASURE.
- MEASURE:
  - `analyzer_enable` = 1 for exactly L cycles, where L is the latched length.
  - A 32-bit counter runs 0..L-1. At L-1, go to DUMP with slot index i = 1.
- DUMP, slot i (`HOLD_CYCLES` cycles, s = 0..HOLD_CYCLES-1):
  - `result_select` = i for the whole slot.
  - At s = 1: capture `result_data` into `register_write`.
  - For s >= 1: `register_operation` = 2, `register_number` = i.
  - At s = 0: `register_operation` = 0.
  - After the last cycle of slot REGISTERS_NUMBER: increment `window_count`, go to DONE.
- DONE:
  - `irq` = 1; write-port outputs and `result_select` are 0.
  - `irq_ack` -> IDLE. `irq_ack` is ignored in every other state.
- `cmd_start` is ignored while `busy`.
- `cmd_abort` in any non-IDLE state -> IDLE next cycle:
  - all outputs return to 0, including `irq`;
  - `window_count` is unchanged;
  - registers not yet written stay unwritten.
- Abort and start in the same IDLE cycle: abort wins; nothing starts.
- `reset` overrides everything. After reset: state IDLE, all outputs 0, `window_count` = 0.

## Timing
- `cmd_start` high in cycle 0 gives:
  - `analyzer_clear` high in cycles 1..CLEAR_CYCLES;
  - `analyzer_enable` high in cycles CLEAR_CYCLES+1 .. CLEAR_CYCLES+L;
  - DUMP lasting REGISTERS_NUMBER*HOLD_CYCLES cycles;
  - `irq` high from cycle CLEAR_CYCLES+L+REGISTERS_NUMBER*HOLD_CYCLES+1.
- `analyzer_clear` and `analyzer_enable` are never high in the same cycle.
- All outputs are registered.
- L = 1 is legal: `analyzer_enable` is high for one cycle.
- L = 0xFFFFFFFF is legal: the counter does not overflow.

## Configuration
- `FREQUENCY_SCHEDULER_AUTO_REPEAT_EN` defined:
  - Adds input `auto_repeat` (1 bit).
  - In DONE, `irq_ack` with `auto_repeat` = 1 goes to CLEAR, reusing the latched L.
  - `auto_repeat` = 0 behaves as without the macro.
- Not defined:
  - No `auto_repeat` port.
  - DONE + `irq_ack` always goes to IDLE.

## Structure
- Shared package contents:
  - state enum;
  - register operation codes: NONE = 0, WRITE = 2;
  - `result_select` width.
- One sub-module, `measurement_window_counter`:
  - loadable 32-bit down-counter with terminal-count output;
  - reused for CLEAR, MEASURE and DUMP slot timing.

## Test plan
- Basic cycle: `window_cycles` = 10, `CLEAR_CYCLES` = 2, `HOLD_CYCLES` = 4, start at cycle 0. Required:
  - clear high in cycles 1–2;
  - enable high in cycles 3–12;
  - 7 writes to registers 1..7 carrying the mux values (e.g. 0x100+i);
  - `irq` high at cycle 41;
  - `window_count` = 1.
- Default window: `window_cycles` = 0 with `DEFAULT_WINDOW_CYCLES` = 20 -> enable high for exactly 20 cycles.
- Abort mid-dump: abort during slot 3 -> IDLE next cycle; registers 4..7 not written; `irq` stays 0; `window_count` unchanged.
- Simultaneous start+abort in IDLE -> stays IDLE. Start while MEASURE -> ignored; window length unchanged.
- Ack: `irq_ack` in MEASURE is ignored. `irq_ack` in DONE -> `irq` low next cycle and `busy` = 0. With the macro and `auto_repeat` = 1 -> clear reasserts next cycle; the second window gives `window_count` = 2.
- Reset asserted in MEASURE -> next cycle all outputs 0 and `window_count` = 0.
